// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package imem_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 32;

  // addi x0, x0, 0: returned in place of data for faulting fetches.
  localparam logic [IMEM_DATA_W-1:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] data;
    logic [IMEM_ADDR_W-1:0] addr;
    logic                   err;
  } rsp_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_fetch_responder_rsp_fifo.sv
// Response FIFO with a registered head: the head outputs keep their last value
// once the FIFO drains, and a synchronous clear empties it without touching them.
module imem_fetch_responder_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                push_i,
  input  rsp_t                push_data_i,
  input  logic                pop_i,
  output rsp_t                head_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [ptr_w(DEPTH):0] count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  rsp_t          mem_q [DEPTH];
  rsp_t          head_q, head_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = bump(wr_ptr_q);
      if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      // Next head: an entry already stored, else the one arriving into an empty FIFO.
      if ((cnt_q - CW'(do_pop)) != '0) begin
        head_d = mem_q[rd_ptr_d];
      end else if (do_push) begin
        head_d = push_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign head_o  = head_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CW'(DEPTH));

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: credit-gated request accept, RAM read, fixed-latency
// pipe into a response FIFO. Define IMEM_FLUSH_EN to add the flush_i port.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int MEM_AW     = 8,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IMEM_ADDR_W-1:0] req_addr_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IMEM_DATA_W-1:0] rsp_data_o,
  output logic [IMEM_ADDR_W-1:0] rsp_addr_o,
  output logic                   rsp_err_o,
`ifdef IMEM_FLUSH_EN
  input  logic                   flush_i,
`endif
  input  logic                   wr_en_i,
  input  logic [MEM_AW-1:0]      wr_addr_i,
  input  logic [IMEM_DATA_W-1:0] wr_data_i
);

  localparam int ADDR_W = IMEM_ADDR_W;
  localparam int DATA_W = IMEM_DATA_W;
  localparam int CW     = ptr_w(FIFO_DEPTH) + 1;
  localparam int IW     = $clog2(LATENCY + 1);

  logic              flush;
  logic              req_err, accept;
  logic [MEM_AW-1:0] rd_idx;

`ifdef IMEM_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[ADDR_W-1:MEM_AW+2] != '0);
  assign rd_idx  = req_addr_i[MEM_AW+1:2];
  assign accept  = req_valid_i && req_ready_o;

  // Instruction RAM; its read register doubles as the first data pipe stage.
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] dat_q [LATENCY];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (accept && !req_err) dat_q[0] <= mem[rd_idx];
    for (int i = 1; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
  end

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]  addr_q [LATENCY];
  logic [ADDR_W-1:0]  addr_d [LATENCY];
  logic               err_q  [LATENCY];
  logic               err_d  [LATENCY];

  // Flush drops the older stages but keeps a request accepted in the same cycle.
  always_comb begin
    vld_d[0]  = accept;
    addr_d[0] = req_addr_i;
    err_d[0]  = req_err;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1] && !flush;
      addr_d[i] = addr_q[i-1];
      err_d[i]  = err_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= addr_d[i];
        err_q[i]  <= err_d[i];
      end
    end
  end

  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  rsp_t          push_rsp, head_rsp;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + IW'(vld_q[i]);
  end

  // Credit counts FIFO occupancy before any pop this cycle, so the FIFO cannot overflow.
  assign req_ready_o = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;

  always_comb begin
    push_rsp.data = err_q[LATENCY-1] ? NOP_INSN : dat_q[LATENCY-1];
    push_rsp.addr = addr_q[LATENCY-1];
    push_rsp.err  = err_q[LATENCY-1];
  end

  assign fifo_pop  = rsp_valid_o && rsp_ready_i;
  assign fifo_push = vld_q[LATENCY-1] && (!fifo_full || fifo_pop);

  imem_fetch_responder_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush),
    .push_i      (fifo_push),
    .push_data_i (push_rsp),
    .pop_i       (fifo_pop),
    .head_o      (head_rsp),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign rsp_valid_o = !fifo_empty;
  assign rsp_data_o  = head_rsp.data;
  assign rsp_addr_o  = head_rsp.addr;
  assign rsp_err_o   = head_rsp.err;

endmodule
